// File: rtl/lut_arbiter_pkg.sv
// Shared definitions for the LUT arbiter: handle encoding, FSM state
// encoding and the round-robin pointer advance.
package lut_arbiter_pkg;

  localparam int LUT_HANDLE_WIDTH = 4;

  localparam logic [LUT_HANDLE_WIDTH-1:0] LUT_HANDLE_SIN  = 4'd0;
  localparam logic [LUT_HANDLE_WIDTH-1:0] LUT_HANDLE_TANH = 4'd1;

  typedef enum logic [2:0] {
    LUT_ARB_STATE_IDLE      = 3'd0,
    LUT_ARB_STATE_WAIT_BUSY = 3'd1,
    LUT_ARB_STATE_WAIT_DONE = 3'd2,
    LUT_ARB_STATE_RESPOND   = 3'd3,
    LUT_ARB_STATE_FAULT     = 3'd4
  } lut_arb_state_e;

  // Index after idx, wrapping at n; used to advance the round-robin pointer.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lut_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of req,
// scanning upward from ptr and wrapping. Reusable by any shared-resource
// arbiter that keeps its own pointer.
module lut_arbiter_rr_pick #(
  parameter int n = 4,
  localparam int iw = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0]  req,
  input  logic [iw-1:0] ptr,
  output logic          valid,
  output logic [iw-1:0] idx
);

  logic [iw-1:0] cand;

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = n - 1; k >= 0; k--) begin
      cand = iw'((int'(ptr) + k) % n);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/lut_arbiter.sv
// Round-robin front end letting n_clients cores share one lut_master.
// Issues a one-cycle lut_req, waits for the result, returns it to the
// granted client, and falls into a sticky fault on a rejected or hung
// LUT request, after which every request is answered with an error.
module lut_arbiter
  import lut_arbiter_pkg::*;
#(
  parameter int n_clients      = 4,
  parameter int data_width     = 16,
  parameter int handle_width   = LUT_HANDLE_WIDTH,
  parameter int timeout_cycles = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [n_clients-1:0]              client_req,
  input  logic [n_clients*handle_width-1:0] client_handle,
  input  logic [n_clients*data_width-1:0]   client_arg,
  output logic [n_clients-1:0]              client_done,
  output logic [n_clients-1:0]              client_error,
  output logic [data_width-1:0]             client_data,
  output logic                              lut_req,
  output logic [handle_width-1:0]           lut_handle,
  output logic [data_width-1:0]             lut_arg,
  input  logic [data_width-1:0]             lut_data,
  input  logic                              lut_ready,
  input  logic                              lut_invalid
);

  localparam int IW = (n_clients > 1) ? $clog2(n_clients) : 1;
  localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

  lut_arb_state_e            state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      lut_req_q, lut_req_d;
  logic [handle_width-1:0]   lut_handle_q, lut_handle_d;
  logic [data_width-1:0]     lut_arg_q, lut_arg_d;
  logic [n_clients-1:0]      client_done_q, client_done_d;
  logic [n_clients-1:0]      client_error_q, client_error_d;
  logic [data_width-1:0]     client_data_q, client_data_d;

  logic                      pick_valid;
  logic [IW-1:0]             pick_idx;
  logic [IW-1:0]             pick_next;

  lut_arbiter_rr_pick #(.n(n_clients)) u_rr_pick (
    .req   (client_req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_next = IW'(rr_next(int'(pick_idx), n_clients));

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path infers a latch.
    state_d        = state_q;
    idx_d          = idx_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    lut_req_d      = 1'b0;
    lut_handle_d   = lut_handle_q;
    lut_arg_d      = lut_arg_q;
    client_done_d  = '0;
    client_error_d = '0;
    client_data_d  = client_data_q;

    unique case (state_q)
      LUT_ARB_STATE_IDLE: begin
        if (lut_ready && pick_valid) begin
          idx_d        = pick_idx;
          lut_handle_d = client_handle[int'(pick_idx)*handle_width +: handle_width];
          lut_arg_d    = client_arg[int'(pick_idx)*data_width +: data_width];
          lut_req_d    = 1'b1;
          rr_ptr_d     = pick_next;
          state_d      = LUT_ARB_STATE_WAIT_BUSY;
        end
      end

      LUT_ARB_STATE_WAIT_BUSY: begin
        // lut_master samples lut_req this cycle; the default drops it.
        cnt_d   = '0;
        state_d = LUT_ARB_STATE_WAIT_DONE;
      end

      LUT_ARB_STATE_WAIT_DONE: begin
        // A result wins over a simultaneous invalid flag.
        if (lut_ready) begin
          client_data_d        = lut_data;
          client_done_d[idx_q] = 1'b1;
          state_d              = LUT_ARB_STATE_RESPOND;
        end else if (lut_invalid || cnt_q == CW'(timeout_cycles - 1)) begin
          client_data_d         = '0;
          client_done_d[idx_q]  = 1'b1;
          client_error_d[idx_q] = 1'b1;
          state_d               = LUT_ARB_STATE_FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      LUT_ARB_STATE_RESPOND: begin
        // Gives the served client a cycle to drop its request before rearbitration.
        state_d = LUT_ARB_STATE_IDLE;
      end

      LUT_ARB_STATE_FAULT: begin
        // Answer requesters with an error; skip the cycle where a pulse is showing.
        if (!(|client_done_q) && pick_valid) begin
          idx_d                    = pick_idx;
          rr_ptr_d                 = pick_next;
          client_data_d            = '0;
          client_done_d[pick_idx]  = 1'b1;
          client_error_d[pick_idx] = 1'b1;
        end
      end

      default: state_d = LUT_ARB_STATE_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= LUT_ARB_STATE_IDLE;
      idx_q          <= '0;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      lut_req_q      <= 1'b0;
      lut_handle_q   <= '0;
      lut_arg_q      <= '0;
      client_done_q  <= '0;
      client_error_q <= '0;
      client_data_q  <= '0;
    end else begin
      // NOTE: non-blocking here so every flop updates from pre-edge values.
      state_q        <= state_d;
      idx_q          <= idx_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      lut_req_q      <= lut_req_d;
      lut_handle_q   <= lut_handle_d;
      lut_arg_q      <= lut_arg_d;
      client_done_q  <= client_done_d;
      client_error_q <= client_error_d;
      client_data_q  <= client_data_d;
    end
  end

  assign lut_req      = lut_req_q;
  assign lut_handle   = lut_handle_q;
  assign lut_arg      = lut_arg_q;
  assign client_done  = client_done_q;
  assign client_error = client_error_q;
  assign client_data  = client_data_q;

endmodule
